// File: rtl/deserializer_if.sv
//------------------------------------------------------------------------------
// deserializer_if : serial-in / parallel-out handshake bundle for deserializer
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface deserializer_if #(
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 16
);
   logic [WORD_W-1:0]           serial_data;
   logic                        rx_valid;
   logic                        rx_last;
   logic                        rx_ready;
   logic [WORD_W*NUM_WORDS-1:0] parallel_data;
   logic                        tx;
   logic                        tx_ack;
   logic                        short_frame;

   // master: the surrounding environment (word producer and frame consumer)
   modport master (
      output serial_data, rx_valid, rx_last, tx_ack,
      input  rx_ready, parallel_data, tx, short_frame
   );

   // slave: the deserializer itself
   modport slave (
      input  serial_data, rx_valid, rx_last, tx_ack,
      output rx_ready, parallel_data, tx, short_frame
   );
endinterface

`default_nettype wire

// File: rtl/deserializer.sv
//------------------------------------------------------------------------------
// deserializer : packs NUM_WORDS serial words (first word in the MSB slot)
//                into one parallel frame, with early termination and padding.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module deserializer #(
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 16,
   parameter int CNT_W     = 5
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   deserializer_if.slave         bus,
   output logic [CNT_W-1:0]      count
);

   localparam int               c_frame_w  = WORD_W * NUM_WORDS;
   localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_WORDS - 1);

   logic [c_frame_w-1:0] r_asm;
   logic [c_frame_w-1:0] r_pdata;
   logic                 r_tx;
   logic                 r_short;
   logic [CNT_W-1:0]     r_count;

   logic                 w_ready;
   logic                 w_accept;
   logic                 w_complete;
   logic [c_frame_w-1:0] w_asm_next;

   assign w_ready    = !r_tx || bus.tx_ack;
   assign w_accept   = bus.rx_valid && w_ready;
   assign w_complete = w_accept && ((r_count == c_last_idx) || bus.rx_last);

   // Slot k lives at [(NUM_WORDS-1-k)*WORD_W +: WORD_W]; the first word of a
   // frame wipes the stale contents so short frames come out zero-padded.
   always_comb begin
      w_asm_next = (r_count == '0) ? '0 : r_asm;
      for (int s = 0; s < NUM_WORDS; s++) begin
         if (r_count == CNT_W'(NUM_WORDS - 1 - s)) begin
            w_asm_next[s*WORD_W +: WORD_W] = bus.serial_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_asm   <= '0;
         r_pdata <= '0;
         r_tx    <= 1'b0;
         r_short <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_asm <= w_asm_next;
            if (w_complete) begin
               r_pdata <= w_asm_next;
               r_tx    <= 1'b1;
               r_short <= (r_count != c_last_idx);
               r_count <= '0;
            end else begin
               r_count <= r_count + CNT_W'(1);
            end
         end
         // An ack coinciding with a new completion hands over without a bubble
         if (r_tx && bus.tx_ack && !w_complete) begin
            r_tx <= 1'b0;
         end
      end
   end

   assign bus.rx_ready      = w_ready;
   assign bus.parallel_data = r_pdata;
   assign bus.tx            = r_tx;
   assign bus.short_frame   = r_short;
   assign count             = r_count;

endmodule

`default_nettype wire

// File: tb/tb_deserializer.sv
//------------------------------------------------------------------------------
// tb_deserializer : directed self-checking bench for deserializer
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_deserializer;

   logic         clk;
   logic         rst_n;
   logic [4:0]   count;
   int           n_cmp;
   int           n_err;
   int           n_frames;
   logic [255:0] exp_frame;
   logic [255:0] held;

   deserializer_if #(.WORD_W(16), .NUM_WORDS(16)) bus ();

   deserializer #(.WORD_W(16), .NUM_WORDS(16), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic last, input logic ack);
      bus.serial_data = d;
      bus.rx_valid    = 1'b1;
      bus.rx_last     = last;
      bus.tx_ack      = ack;
      #1;
      chk("rx_ready_on_send", 256'(bus.rx_ready), 256'd1);
      tick();
   endtask

   task automatic idle(input logic ack);
      bus.rx_valid = 1'b0;
      bus.rx_last  = 1'b0;
      bus.tx_ack   = ack;
      tick();
   endtask

   initial begin
      n_cmp = 0; n_err = 0; n_frames = 0;
      rst_n = 1'b0;
      bus.serial_data = '0; bus.rx_valid = 1'b0; bus.rx_last = 1'b0; bus.tx_ack = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_tx", 256'(bus.tx), 256'd0);
      chk("rst_pdata", bus.parallel_data, 256'd0);
      chk("rst_short", 256'(bus.short_frame), 256'd0);
      chk("rst_count", 256'(count), 256'd0);
      chk("rst_ready", 256'(bus.rx_ready), 256'd1);
      rst_n = 1'b1;
      tick();

      // Full frame 0..F with tx_ack held high
      for (int i = 0; i < 16; i++) begin
         send(16'(i), 1'b0, 1'b1);
         if (i == 4) chk("count_mid", 256'(count), 256'd5);
         if (i < 15) chk("tx_low_mid", 256'(bus.tx), 256'd0);
      end
      chk("full_tx", 256'(bus.tx), 256'd1);
      chk("full_pdata", bus.parallel_data,
          256'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F);
      chk("full_short", 256'(bus.short_frame), 256'd0);
      chk("full_count", 256'(count), 256'd0);
      idle(1'b1);
      chk("full_ack_tx", 256'(bus.tx), 256'd0);

      // Held output with tx_ack low; a 17th word must be refused
      for (int i = 0; i < 16; i++) send(16'(i), 1'b0, 1'b0);
      chk("hold_tx0", 256'(bus.tx), 256'd1);
      held = bus.parallel_data;
      chk("hold_pdata0", held,
          256'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F);
      bus.serial_data = 16'hDEAD; bus.rx_valid = 1'b1; bus.tx_ack = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("hold_ready", 256'(bus.rx_ready), 256'd0);
         tick();
         chk("hold_tx", 256'(bus.tx), 256'd1);
         chk("hold_pdata", bus.parallel_data, held);
      end
      chk("hold_count", 256'(count), 256'd0);
      idle(1'b1);
      chk("hold_release_tx", 256'(bus.tx), 256'd0);
      bus.tx_ack = 1'b0;
      #1;
      chk("hold_release_ready", 256'(bus.rx_ready), 256'd1);
      chk("hold_no_17th", 256'(count), 256'd0);
      tick();

      // Short frame of three words
      send(16'hAAAA, 1'b0, 1'b0);
      send(16'hBBBB, 1'b0, 1'b0);
      send(16'hCCCC, 1'b1, 1'b0);
      chk("short_tx", 256'(bus.tx), 256'd1);
      chk("short_pdata", bus.parallel_data, {48'hAAAA_BBBB_CCCC, 208'd0});
      chk("short_flag", 256'(bus.short_frame), 256'd1);
      chk("short_count", 256'(count), 256'd0);
      idle(1'b1);
      chk("short_ack_tx", 256'(bus.tx), 256'd0);

      // 48-word continuous stream, tx_ack held high
      exp_frame = '0;
      for (int i = 1; i <= 48; i++) begin
         exp_frame = {exp_frame[239:0], 16'(16'h0200 + i)};
         send(16'(16'h0200 + i), 1'b0, 1'b1);
         if (bus.tx === 1'b1) n_frames++;
         chk("stream_tx", 256'(bus.tx), 256'((i % 16) == 0));
         if ((i % 16) == 0) chk("stream_pdata", bus.parallel_data, exp_frame);
      end
      chk("stream_frames", 256'(n_frames), 256'd3);
      idle(1'b1);

      // Asynchronous reset in mid-frame
      for (int i = 0; i < 7; i++) send(16'hEEEE, 1'b0, 1'b1);
      chk("abort_count_pre", 256'(count), 256'd7);
      bus.rx_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_count", 256'(count), 256'd0);
      chk("abort_tx", 256'(bus.tx), 256'd0);
      chk("abort_pdata", bus.parallel_data, 256'd0);
      tick();
      rst_n = 1'b1;
      tick();
      exp_frame = '0;
      for (int i = 0; i < 16; i++) begin
         exp_frame = {exp_frame[239:0], 16'(16'h0100 + i)};
         send(16'(16'h0100 + i), 1'b0, 1'b1);
      end
      chk("abort_clean_tx", 256'(bus.tx), 256'd1);
      chk("abort_clean_pdata", bus.parallel_data, exp_frame);
      chk("abort_clean_short", 256'(bus.short_frame), 256'd0);
      idle(1'b1);

      // Single-word frame then a full frame with rx_last on the 16th word
      send(16'h1234, 1'b1, 1'b1);
      chk("one_tx", 256'(bus.tx), 256'd1);
      chk("one_pdata", bus.parallel_data, {16'h1234, 240'd0});
      chk("one_short", 256'(bus.short_frame), 256'd1);
      exp_frame = '0;
      for (int i = 0; i < 16; i++) begin
         exp_frame = {exp_frame[239:0], 16'(16'h5000 + i)};
         send(16'(16'h5000 + i), (i == 15), 1'b1);
         if (i == 0) chk("one_then_tx_low", 256'(bus.tx), 256'd0);
      end
      chk("second_tx", 256'(bus.tx), 256'd1);
      chk("second_pdata", bus.parallel_data, exp_frame);
      chk("second_short", 256'(bus.short_frame), 256'd0);
      chk("second_count", 256'(count), 256'd0);
      idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receives a stream of 16-bit words and packs each group of 16 words into one 256-bit parallel word for the ELM engine datapath.
- Inverse of the engine's 256-to-16 serializer: the first word received lands in bits [255:240], the last in [15:0].
- Supports early frame termination with zero padding.
- An assembly register is separate from the output register, so the next frame can be collected while the current one waits at the output.

Parameters:
- WORD_W, 16, width of one serial word.
- NUM_WORDS, 16, words per parallel frame. Output width is WORD_W*NUM_WORDS = 256.
- CNT_W, 5, width of the count output. Must be at least clog2(NUM_WORDS)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- serial_data  input  WORD_W  incoming word.
- rx_valid  input  1  serial_data is valid this cycle.
- rx_last  input  1  qualifies serial_data as the final word of the frame. Only sampled when rx_valid and rx_ready are both high.
- rx_ready  output  1  the block accepts a word this cycle.
- parallel_data  output  WORD_W*NUM_WORDS  assembled frame.
- tx  output  1  parallel_data is valid.
- tx_ack  input  1  consumer accepts parallel_data.
- short_frame  output  1  the frame on parallel_data ended early via rx_last and has zero-padded tail slots.
- count  output  CNT_W  number of words accepted into the current assembly frame, 0..NUM_WORDS-1.

Behaviour:
- Reset (async assert, sync deassert):
  - parallel_data=0, tx=0, short_frame=0, count=0.
  - Assembly register cleared.
  - A reset in mid-frame discards the partial frame and any held output.
- rx_ready is combinational: rx_ready = !tx | tx_ack. Input stalls only while an unaccepted frame is held.
- Word accept = rx_valid & rx_ready.
- On accept with count=k:
  - serial_data is written to assembly slot bits [(NUM_WORDS-1-k)*WORD_W +: WORD_W].
  - If k=0, all other slots are cleared in the same cycle.
- Frame completes on an accept where k=NUM_WORDS-1 or rx_last=1:
  - Next cycle: parallel_data = assembled value, including the slot just written. Unwritten slots are 0.
  - tx=1.
  - short_frame = (k != NUM_WORDS-1).
  - count=0.
- Non-completing accept: count increments by 1.
- rx_last on the 16th word is legal, gives short_frame=0, and has no extra effect.
- Output latency: tx rises 1 cycle after the completing accept.
- Output hold: while tx=1 and tx_ack=0, parallel_data and short_frame are stable and rx_ready=0. count holds its value, which may be mid-frame.
- tx_ack while tx=1, no completion in the same cycle: tx falls next cycle.
- tx_ack and a completing accept in the same cycle: the new frame loads, tx stays 1, and there is no bubble. Sustained throughput is 1 word/cycle.
- tx_ack while tx=0 is ignored.
- rx_valid=0: no state change. serial_data and rx_last are don't-care.
- Once tx is raised, it stays high until tx_ack. The block never drops a frame.

Test Plan:
- Reset, then 16 back-to-back accepts of serial_data=16'h0000..16'h000F with tx_ack held 1 → one cycle after the 16th accept, tx=1, parallel_data=256'h0000_0001_0002_…_000F, short_frame=0, count=0.
- Same 16 words with tx_ack=0 → tx stays 1 and parallel_data stays stable for 10 cycles; a 17th word with rx_valid=1 sees rx_ready=0 and is not taken; a single tx_ack pulse drops tx on the next cycle and rx_ready returns to 1.
- 3 words 16'hAAAA, 16'hBBBB, 16'hCCCC with rx_last on the third → parallel_data[255:208]=48'hAAAA_BBBB_CCCC, remaining bits 0, short_frame=1.
- Continuous stream of 48 words, rx_valid and tx_ack held 1 → exactly 3 tx-qualified frames on consecutive 16-cycle boundaries; rx_ready never deasserts.
- rst_n pulled low after 7 words accepted → count=0 and tx=0 immediately (asynchronously); the next 16 words form a clean frame with no residue from the aborted one.
- Single-word frame 16'h1234 with rx_last, immediately followed by a full 16-word frame → first output 16'h1234 in [255:240], rest zero, short_frame=1; second frame correct with short_frame=0.
